// File: rtl/countdown_pkg.sv
// Shared types and constants for the countdown run-control slice.
// Compile-time only; no logic, no latency, no flow control.
package countdown_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        PAUSE,
        DONE,
        RELOAD
    } state_t;

    localparam int TICK_DIV_1HZ = 100_000_000;
    localparam int TICK_DIV_SIM = 4;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider: pulses tick once every TICK_DIV cycles while run is high.
// Latency: tick is combinational from the count register; the count holds when run is low.
// Backpressure: none; clr (or rst) forces the phase back to zero.
module tick_prescaler
    import countdown_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_1HZ,
    parameter int DIV_W    = 27
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             clr,
    output logic             tick,
    output logic [DIV_W-1:0] count
);

    localparam logic [DIV_W-1:0] LAST = DIV_W'(TICK_DIV - 1);

    assign tick = run && (count == LAST);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (run) begin
            count <= tick ? '0 : count + DIV_W'(1);
        end
    end

endmodule

// File: rtl/countdown_ctrl.sv
// Start/pause/clear run control for the min/sec down-counters; AUTO_RELOAD_EN adds a one-cycle RELOAD on terminal tick.
// Latency: enables/tick combinational from registered state and prescaler; state changes one edge after a pulse.
// Backpressure: none; pulse inputs are consumed in the cycle they arrive (clear > pause > start).
module countdown_ctrl
    import countdown_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_1HZ,
    parameter int DIV_W    = 27
) (
    input  logic clk,
    input  logic rst,
    input  logic start_pulse,
    input  logic pause_pulse,
    input  logic clear_pulse,
    input  logic sec_is_zero,
    input  logic min_is_zero,
    output logic sec_count_en,
    output logic min_count_en,
    output logic load_n,
    output logic tick,
    output logic running,
    output logic done
);

    state_t             state;
    state_t             state_nxt;
    logic               presc_run;
    logic               presc_clr;
    logic [DIV_W-1:0]   unused_presc_count;
    logic               terminal;

    // PAUSE keeps the prescaler phase so a resume lands on the same sub-second offset
    assign presc_run = (state == RUN);
    assign presc_clr = (state != RUN) && (state != PAUSE);
    assign terminal  = sec_is_zero && min_is_zero;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV),
        .DIV_W    (DIV_W)
    ) u_prescaler (
        .clk   (clk),
        .rst   (rst),
        .run   (presc_run),
        .clr   (presc_clr),
        .tick  (tick),
        .count (unused_presc_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        sec_count_en = 1'b0;
        min_count_en = 1'b0;
        case (state)
            IDLE: begin
                if (clear_pulse) begin
                    state_nxt = IDLE;
                end else if (start_pulse) begin
                    state_nxt = terminal ? DONE : RUN;
                end
            end
            RUN: begin
                if (clear_pulse) begin
                    state_nxt = IDLE;
                end else begin
                    // a pause on a tick still lets that tick's decrement through
                    if (tick && !terminal) begin
                        sec_count_en = 1'b1;
                        min_count_en = sec_is_zero & ~min_is_zero;
                    end
                    if (tick && terminal) begin
`ifdef AUTO_RELOAD_EN
                        state_nxt = RELOAD;
`else
                        state_nxt = DONE;
`endif
                    end else if (pause_pulse) begin
                        state_nxt = PAUSE;
                    end
                end
            end
            PAUSE: begin
                if (clear_pulse) begin
                    state_nxt = IDLE;
                end else if (pause_pulse || start_pulse) begin
                    state_nxt = RUN;
                end
            end
            DONE: begin
                if (clear_pulse) begin
                    state_nxt = IDLE;
                end
            end
`ifdef AUTO_RELOAD_EN
            RELOAD: begin
                state_nxt = clear_pulse ? IDLE : RUN;
            end
`endif
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

`ifdef AUTO_RELOAD_EN
    assign load_n  = !((state == IDLE) || (state == RELOAD));
`else
    assign load_n  = (state != IDLE);
`endif
    assign running = (state == RUN);
    assign done    = (state == DONE);

endmodule

// File: tb/tb_countdown_ctrl.sv
// Directed-vector bench for countdown_ctrl at TICK_DIV=4; outputs checked as {sec_en,min_en,load_n,tick,running,done}.
// Inputs packed as {start,pause,clear,sec_is_zero,min_is_zero}.
module tb_countdown_ctrl;
    import countdown_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_pulse = 1'b0;
    logic pause_pulse = 1'b0;
    logic clear_pulse = 1'b0;
    logic sec_is_zero = 1'b0;
    logic min_is_zero = 1'b0;
    logic sec_count_en;
    logic min_count_en;
    logic load_n;
    logic tick;
    logic running;
    logic done;

    int n_checks = 0;
    int n_passed = 0;

    typedef struct {
        logic [4:0] in;
        logic [5:0] exp;
    } vec_t;

    vec_t vecs [23];

    always #5 clk = ~clk;

    countdown_ctrl #(
        .TICK_DIV (TICK_DIV_SIM),
        .DIV_W    (3)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start_pulse  (start_pulse),
        .pause_pulse  (pause_pulse),
        .clear_pulse  (clear_pulse),
        .sec_is_zero  (sec_is_zero),
        .min_is_zero  (min_is_zero),
        .sec_count_en (sec_count_en),
        .min_count_en (min_count_en),
        .load_n       (load_n),
        .tick         (tick),
        .running      (running),
        .done         (done)
    );

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        {start_pulse, pause_pulse, clear_pulse, sec_is_zero, min_is_zero} = 5'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // drive one cycle of inputs, then compare the outputs mid-cycle
    task automatic cyc(input logic [4:0] in, input logic [5:0] exp, input string name);
        logic [5:0] act;
        @(posedge clk);
        #1;
        {start_pulse, pause_pulse, clear_pulse, sec_is_zero, min_is_zero} = in;
        @(negedge clk);
        act = {sec_count_en, min_count_en, load_n, tick, running, done};
        n_checks++;
        if (act === exp) begin
            n_passed++;
        end else begin
            $display("FAIL %s: got %b expected %b (sec_en,min_en,load_n,tick,running,done)",
                     name, act, exp);
        end
    endtask

    initial begin
        vecs[0]  = '{5'b10000, 6'b000000};  // IDLE, start
        vecs[1]  = '{5'b00000, 6'b001010};  // RUN count0
        vecs[2]  = '{5'b00000, 6'b001010};
        vecs[3]  = '{5'b00000, 6'b001010};
        vecs[4]  = '{5'b00000, 6'b101110};  // tick, sec only
        vecs[5]  = '{5'b00000, 6'b001010};
        vecs[6]  = '{5'b00000, 6'b001010};
        vecs[7]  = '{5'b00000, 6'b001010};
        vecs[8]  = '{5'b00010, 6'b111110};  // tick with sec zero -> borrow minute
        vecs[9]  = '{5'b00010, 6'b001010};  // sec zero off-tick: no enables
        vecs[10] = '{5'b01000, 6'b001010};  // pause at count1
        vecs[11] = '{5'b00000, 6'b001000};  // PAUSE
        vecs[12] = '{5'b01000, 6'b001000};  // pause toggle resumes
        vecs[13] = '{5'b00000, 6'b001010};  // RUN count2
        vecs[14] = '{5'b01000, 6'b101110};  // tick + pause: enables still issued
        vecs[15] = '{5'b10000, 6'b001000};  // PAUSE, start resumes
        vecs[16] = '{5'b00100, 6'b001010};  // RUN, clear
        vecs[17] = '{5'b01000, 6'b000000};  // IDLE ignores pause
        vecs[18] = '{5'b10011, 6'b000000};  // start with zero init -> DONE
        vecs[19] = '{5'b11000, 6'b001001};  // DONE ignores start/pause
        vecs[20] = '{5'b00000, 6'b001001};
        vecs[21] = '{5'b00100, 6'b001001};  // clear
        vecs[22] = '{5'b00000, 6'b000000};  // back to IDLE, loading

        do_reset();
        for (int i = 0; i < 10; i++) cyc(5'b00000, 6'b000000, "reset_idle");

        for (int i = 0; i < 23; i++) cyc(vecs[i].in, vecs[i].exp, $sformatf("vec%0d", i));

        // pause after two RUN cycles, long hold, resume keeps phase
        do_reset();
        cyc(5'b10000, 6'b000000, "a_start");
        cyc(5'b00000, 6'b001010, "a_run0");
        cyc(5'b01000, 6'b001010, "a_pause");
        for (int i = 0; i < 20; i++) cyc(5'b00000, 6'b001000, "a_hold");
        cyc(5'b10000, 6'b001000, "a_resume");
        cyc(5'b00000, 6'b001010, "a_run2");
        cyc(5'b00000, 6'b101110, "a_first_tick");

        // terminal tick
        do_reset();
        cyc(5'b10000, 6'b000000, "b_start");
        for (int i = 0; i < 3; i++) cyc(5'b00011, 6'b001010, "b_run");
        cyc(5'b00011, 6'b001110, "b_terminal");
`ifdef AUTO_RELOAD_EN
        cyc(5'b00000, 6'b000000, "b_reload");
        for (int i = 0; i < 3; i++) cyc(5'b00000, 6'b001010, "b_rerun");
        cyc(5'b00000, 6'b101110, "b_rerun_tick");
`else
        for (int i = 0; i < 5; i++) cyc(5'b00000, 6'b001001, "b_done");
        cyc(5'b00100, 6'b001001, "b_clear");
        cyc(5'b00000, 6'b000000, "b_idle");
`endif

        // clear + pause on a tick
        do_reset();
        cyc(5'b10000, 6'b000000, "c_start");
        for (int i = 0; i < 3; i++) cyc(5'b00000, 6'b001010, "c_run");
        cyc(5'b01100, 6'b001110, "c_clear_tick");
        cyc(5'b00000, 6'b000000, "c_idle");

        // reset mid-RUN discards the prescaler phase
        do_reset();
        cyc(5'b10000, 6'b000000, "d_start");
        cyc(5'b00000, 6'b001010, "d_run0");
        cyc(5'b00000, 6'b001010, "d_run1");
        do_reset();
        cyc(5'b00000, 6'b000000, "d_idle");
        cyc(5'b10000, 6'b000000, "d_restart");
        for (int i = 0; i < 3; i++) cyc(5'b00000, 6'b001010, "d_run");
        cyc(5'b00000, 6'b101110, "d_tick");

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule
